// File: rtl/pattern_stream_pkg.sv
// -----------------------------------------------------------------------------
// pattern_stream_pkg
//   Shared definitions for the pattern-stream read-side sequencer.
//   - state_t         : sequencer FSM state encoding (3 bits)
//   - DEF_CNT_W       : default width of word counters / num_words
//   - DEF_UFL_W       : default width of the saturating underflow counter
//   - DEF_PREFILL_CYC : default prefill wait (consecutive non-empty cycles)
// -----------------------------------------------------------------------------
package pattern_stream_pkg;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_UFL_W       = 16;
    localparam int DEF_PREFILL_CYC = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/pattern_stream_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk      in   clock, rising edge
//     reset_n  in   asynchronous active-low reset (count -> 0)
//     clr      in   synchronous clear, wins over inc
//     inc      in   increment request
//     count    out  W-bit current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_next = count_reg + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pattern_stream_sequencer.sv
// -----------------------------------------------------------------------------
// pattern_stream_sequencer
//   Read-side controller for the pattern FIFO in the stream clock domain.
//   After a prefill wait (PREFILL_CYC consecutive non-empty cycles) it pulses
//   the FIFO read enable, which doubles as the sensor stream enable, for
//   exactly num_words words, then waits for every read to come back as
//   fifo_valid before pulsing done.
//
//   Optional build macro: PATTERN_STREAM_UFL_STOP_EN
//     defined   -> the first underflow gap in STREAM ends the run: the target
//                  shrinks to the words already issued and the block drains
//                  and finishes.
//     undefined -> streaming stalls during gaps and resumes when the FIFO
//                  refills; every gap cycle is counted.
//
//   Ports:
//     clk         in   stream clock, rising edge
//     reset_n     in   asynchronous active-low reset
//     start       in   run start pulse (accepted in IDLE / DONE only)
//     abort       in   return-to-IDLE pulse, highest priority
//     num_words   in   CNT_W words to stream, sampled on accepted start
//     fifo_empty  in   pattern FIFO empty flag
//     fifo_valid  in   pattern FIFO dout valid (1 cycle after a read)
//     fifo_rd_en  out  FIFO read enable / stream enable (combinational)
//     busy        out  high in PREFILL, STREAM, DRAIN
//     done        out  1-cycle pulse on entry to DONE
//     underflow   out  sticky underflow-gap flag, cleared by start
//     ufl_cnt     out  saturating underflow-gap count, cleared by start
//     words_out   out  fifo_valid beats seen in the current run
// -----------------------------------------------------------------------------
module pattern_stream_sequencer
    import pattern_stream_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PREFILL_CYC = DEF_PREFILL_CYC,
    parameter int UFL_W       = DEF_UFL_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_words,
    input  logic             fifo_empty,
    input  logic             fifo_valid,
    output logic             fifo_rd_en,
    output logic             busy,
    output logic             done,
    output logic             underflow,
    output logic [UFL_W-1:0] ufl_cnt,
    output logic [CNT_W-1:0] words_out
);

    // Prefill counter only has to reach PREFILL_CYC-1; a wait of 0 or 1
    // cycles collapses to "first non-empty cycle".
    localparam int              PF_W    = (PREFILL_CYC < 2) ? 1 : $clog2(PREFILL_CYC);
    localparam logic [PF_W-1:0] PF_LAST = PF_W'((PREFILL_CYC < 2) ? 0 : PREFILL_CYC - 1);

    state_t           state_reg,     state_next;
    logic [CNT_W-1:0] tgt_reg,       tgt_next;
    logic [CNT_W-1:0] issued_reg,    issued_next;
    logic [CNT_W-1:0] words_reg,     words_next;
    logic             underflow_reg, underflow_next;
    logic             done_reg,      done_next;

    logic [PF_W-1:0]  pf_cnt;
    logic [UFL_W-1:0] ufl_cnt_val;

    logic             start_ok;
    logic             busy_int;
    logic             rd_en_int;
    logic             gap;
    logic             words_inc;
    logic [CNT_W-1:0] words_after;
    logic             pf_clr;
    logic             pf_inc;

    assign busy_int = (state_reg == ST_PREFILL) ||
                      (state_reg == ST_STREAM)  ||
                      (state_reg == ST_DRAIN);

    assign start_ok = start && !abort &&
                      ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    // Read enable is purely combinational so it tracks fifo_empty in the same
    // cycle and falls with the state on an asynchronous reset.
    assign rd_en_int = (state_reg == ST_STREAM) && !fifo_empty &&
                       (issued_reg != tgt_reg) && !abort;

    // A gap is a STREAM cycle that wanted to read but the FIFO was empty.
    assign gap = (state_reg == ST_STREAM) && fifo_empty &&
                 (issued_reg != tgt_reg) && !abort;

    // The equality guard keeps words_out from ever passing the target.
    assign words_inc   = busy_int && fifo_valid && (words_reg != tgt_reg);
    assign words_after = words_reg + CNT_W'(words_inc);

    // Prefill streak: restarts on any empty cycle, held across an abort.
    assign pf_clr = start_ok || ((state_reg == ST_PREFILL) && fifo_empty && !abort);
    assign pf_inc = (state_reg == ST_PREFILL) && !fifo_empty && !abort;

    sat_counter #(.W(PF_W)) u_pf_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (pf_clr),
        .inc     (pf_inc),
        .count   (pf_cnt)
    );

    sat_counter #(.W(UFL_W)) u_ufl_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start_ok),
        .inc     (gap),
        .count   (ufl_cnt_val)
    );

    always_comb begin
        state_next     = state_reg;
        tgt_next       = tgt_reg;
        issued_next    = issued_reg;
        words_next     = words_after;
        underflow_next = underflow_reg;
        done_next      = 1'b0;

        if (abort) begin
            // Counters keep their values so software can inspect an aborted run.
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        tgt_next       = num_words;
                        issued_next    = '0;
                        words_next     = '0;
                        underflow_next = 1'b0;
                        if (num_words == '0) begin
                            // Nothing to stream: finish without touching the FIFO.
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_PREFILL;
                        end
                    end
                end

                ST_PREFILL: begin
                    if (!fifo_empty && (pf_cnt == PF_LAST)) begin
                        state_next = ST_STREAM;
                    end
                end

                ST_STREAM: begin
                    if (rd_en_int) begin
                        issued_next = issued_reg + CNT_W'(1);
                        if (issued_reg == (tgt_reg - CNT_W'(1))) begin
                            state_next = ST_DRAIN;
                        end
                    end else if (gap) begin
                        underflow_next = 1'b1;
`ifdef PATTERN_STREAM_UFL_STOP_EN
                        // Shrink the run to what is already in flight and
                        // let DRAIN collect those words.
                        tgt_next   = issued_reg;
                        state_next = ST_DRAIN;
`endif
                    end
                end

                ST_DRAIN: begin
                    // Look at the post-increment count so done follows the
                    // last fifo_valid by a single cycle.
                    if (words_after == tgt_reg) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            tgt_reg       <= '0;
            issued_reg    <= '0;
            words_reg     <= '0;
            underflow_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tgt_reg       <= tgt_next;
            issued_reg    <= issued_next;
            words_reg     <= words_next;
            underflow_reg <= underflow_next;
            done_reg      <= done_next;
        end
    end

    assign fifo_rd_en = rd_en_int;
    assign busy       = busy_int;
    assign done       = done_reg;
    assign underflow  = underflow_reg;
    assign ufl_cnt    = ufl_cnt_val;
    assign words_out  = words_reg;

endmodule

// File: tb/tb_pattern_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pattern_stream_sequencer
//   Self-checking bench for pattern_stream_sequencer: a short vector table for
//   start/abort/zero-length handling, directed multi-cycle runs (basic run,
//   underflow gaps, abort, reset, prefill restart, start while busy) and
//   randomized runs, all checked each cycle against a behavioural run model.
//   Honours PATTERN_STREAM_UFL_STOP_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pattern_stream_sequencer;

    localparam int CNT_W = 32;
    localparam int UFL_W = 16;
    localparam int PF    = 16;

    localparam int MP_IDLE    = 0;
    localparam int MP_PREFILL = 1;
    localparam int MP_STREAM  = 2;
    localparam int MP_DRAIN   = 3;
    localparam int MP_DONE    = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_words;
    logic             fifo_empty;
    logic             fifo_valid;
    logic             fifo_rd_en;
    logic             busy;
    logic             done;
    logic             underflow;
    logic [UFL_W-1:0] ufl_cnt;
    logic [CNT_W-1:0] words_out;

    always #5 clk = ~clk;

    pattern_stream_sequencer #(
        .CNT_W       (CNT_W),
        .PREFILL_CYC (PF),
        .UFL_W       (UFL_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .num_words  (num_words),
        .fifo_empty (fifo_empty),
        .fifo_valid (fifo_valid),
        .fifo_rd_en (fifo_rd_en),
        .busy       (busy),
        .done       (done),
        .underflow  (underflow),
        .ufl_cnt    (ufl_cnt),
        .words_out  (words_out)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural run model ----------------
    int     m_phase;
    longint m_tgt, m_issued, m_words, m_ufl;
    int     m_streak;
    bit     m_uflag, m_done;

    bit valid_pipe;
    bit s_rd, s_busy, s_done;

    // per-run statistics
    int r_first, r_last, r_cnt, r_done_at, r_abort_c;
    bit r_abort_rd, r_busy_after, r_ended;

    typedef struct {
        bit               st;
        bit               ab;
        logic [CNT_W-1:0] nw;
        bit               emp;
        bit               rd;
        bit               bsy;
        bit               dn;
    } vec_t;

    vec_t tbl [14];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = MP_IDLE;
        m_tgt    = 0;
        m_issued = 0;
        m_words  = 0;
        m_ufl    = 0;
        m_streak = 0;
        m_uflag  = 1'b0;
        m_done   = 1'b0;
    endtask

    task automatic model_check();
        bit exp_rd;
        exp_rd = (m_phase == MP_STREAM) && !fifo_empty && (m_issued < m_tgt) && !abort;
        chk1("rd_en",     fifo_rd_en, exp_rd);
        chk1("busy",      busy, (m_phase >= MP_PREFILL) && (m_phase <= MP_DRAIN));
        chk1("done",      done, m_done);
        chk1("underflow", underflow, m_uflag);
        chkn("ufl_cnt",   64'(ufl_cnt), 64'(m_ufl));
        chkn("words_out", 64'(words_out), 64'(m_words));
    endtask

    // Advance the model by one clock edge given this cycle's inputs.
    task automatic model_step(input bit st, input bit ab, input longint nw,
                              input bit emp, input bit vld);
        longint w;
        bit     nd;
        int     need;
        need = (PF < 1) ? 1 : PF;
        nd   = 1'b0;
        w    = m_words;
        if ((m_phase >= MP_PREFILL) && (m_phase <= MP_DRAIN) && vld && (m_words < m_tgt))
            w++;
        if (ab) begin
            m_phase = MP_IDLE;
        end else if (m_phase == MP_IDLE || m_phase == MP_DONE) begin
            if (st) begin
                m_tgt    = nw;
                m_issued = 0;
                w        = 0;
                m_ufl    = 0;
                m_uflag  = 1'b0;
                m_streak = 0;
                if (nw == 0) begin
                    m_phase = MP_DONE;
                    nd      = 1'b1;
                end else begin
                    m_phase = MP_PREFILL;
                end
            end
        end else if (m_phase == MP_PREFILL) begin
            if (emp) begin
                m_streak = 0;
            end else begin
                m_streak++;
                if (m_streak >= need) m_phase = MP_STREAM;
            end
        end else if (m_phase == MP_STREAM) begin
            if (!emp && m_issued < m_tgt) begin
                m_issued++;
                if (m_issued == m_tgt) m_phase = MP_DRAIN;
            end else if (emp && m_issued < m_tgt) begin
                m_uflag = 1'b1;
                if (m_ufl < (64'd1 << UFL_W) - 1) m_ufl++;
`ifdef PATTERN_STREAM_UFL_STOP_EN
                m_tgt   = m_issued;
                m_phase = MP_DRAIN;
`endif
            end
        end else if (m_phase == MP_DRAIN) begin
            if (w == m_tgt) begin
                m_phase = MP_DONE;
                nd      = 1'b1;
            end
        end
        m_words = w;
        m_done  = nd;
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, end at posedge+1.
    task automatic cyc(input bit st, input bit ab, input logic [CNT_W-1:0] nw, input bit emp);
        start      = st;
        abort      = ab;
        num_words  = nw;
        fifo_empty = emp;
        fifo_valid = valid_pipe;
        @(negedge clk);
        s_rd   = fifo_rd_en;
        s_busy = busy;
        s_done = done;
        model_check();
        model_step(st, ab, longint'(nw), emp, valid_pipe);
        valid_pipe = s_rd;
        @(posedge clk);
        #1;
    endtask

    task automatic run_case(input int nw, input int gap_after, input int gap_len,
                            input int pf_hole, input int abort_at, input int bs_at,
                            input int bs_nw, input int rnd_pct, input int budget);
        int reads;
        int gap_rem;
        bit ab, st, emp, aborted;
        reads        = 0;
        gap_rem      = gap_len;
        aborted      = 1'b0;
        r_first      = -1;
        r_last       = -1;
        r_cnt        = 0;
        r_done_at    = -1;
        r_abort_c    = -1;
        r_abort_rd   = 1'b1;
        r_busy_after = 1'b1;
        r_ended      = 1'b0;
        cyc(1'b1, 1'b0, CNT_W'(nw), 1'b0);
        for (int c = 1; c <= budget && !r_ended; c++) begin
            emp = (c == pf_hole);
            if (reads == gap_after && gap_rem > 0) begin
                emp = 1'b1;
                gap_rem--;
            end
            if (rnd_pct > 0 && $urandom_range(99, 0) < rnd_pct) emp = 1'b1;
            ab = (abort_at >= 0) && !aborted && (m_phase == MP_STREAM) && (reads == abort_at);
            st = (c == bs_at) && (m_phase >= MP_PREFILL) && (m_phase <= MP_DRAIN);
            cyc(st, ab, CNT_W'(bs_nw), emp);
            if (s_rd) begin
                if (r_first < 0) r_first = c;
                r_last = c;
                r_cnt++;
                reads++;
            end
            if (ab) begin
                aborted    = 1'b1;
                r_abort_c  = c;
                r_abort_rd = s_rd;
            end
            if (aborted && c == r_abort_c + 1) r_busy_after = s_busy;
            if (s_done && r_done_at < 0) r_done_at = c;
            if ((r_done_at >= 0 && c >= r_done_at + 2) || (aborted && c >= r_abort_c + 4))
                r_ended = 1'b1;
        end
        chk1("run_ended", r_ended, 1'b1);
        $display("run nw=%0d reads=%0d first_rd=%0d last_rd=%0d done_at=%0d ufl=%0d words=%0d",
                 nw, r_cnt, r_first, r_last, r_done_at, ufl_cnt, words_out);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rnw, rab, rbs;

        tbl[0]  = '{1'b0, 1'b0, CNT_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, CNT_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, CNT_W'(0), 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, CNT_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, CNT_W'(2), 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, CNT_W'(0), 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, CNT_W'(0), 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, CNT_W'(0), 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, CNT_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, CNT_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, CNT_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, CNT_W'(0), 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, CNT_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, CNT_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};

        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        num_words  = '0;
        fifo_empty = 1'b0;
        fifo_valid = 1'b0;
        valid_pipe = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_rd_en",     fifo_rd_en, 1'b0);
        chk1("rst_busy",      busy, 1'b0);
        chk1("rst_done",      done, 1'b0);
        chk1("rst_underflow", underflow, 1'b0);
        chkn("rst_ufl_cnt",   64'(ufl_cnt), 64'd0);
        chkn("rst_words_out", 64'(words_out), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: zero-length runs and start/abort priority.
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].st, tbl[i].ab, tbl[i].nw, tbl[i].emp);
            chk1($sformatf("tbl%0d_rd", i),   s_rd,   tbl[i].rd);
            chk1($sformatf("tbl%0d_busy", i), s_busy, tbl[i].bsy);
            chk1($sformatf("tbl%0d_done", i), s_done, tbl[i].dn);
        end

        // Basic run: 40 words after a 16-cycle prefill.
        run_case(40, -1, 0, 0, -1, 0, 0, 0, 200);
        chkn("t1_first_rd",  64'(r_first), 64'd17);
        chkn("t1_rd_count",  64'(r_cnt), 64'd40);
        chkn("t1_rd_span",   64'(r_last - r_first + 1), 64'd40);
        chkn("t1_done_at",   64'(r_done_at), 64'(r_last + 2));
        chk1("t1_underflow", underflow, 1'b0);
        chkn("t1_words",     64'(words_out), 64'd40);

        // Underflow gap: 3 empty cycles after word 20.
        run_case(64, 20, 3, 0, -1, 0, 0, 0, 300);
`ifdef PATTERN_STREAM_UFL_STOP_EN
        chkn("t4_rd_count",  64'(r_cnt), 64'd20);
        chkn("t4_words",     64'(words_out), 64'd20);
        chkn("t4_ufl_cnt",   64'(ufl_cnt), 64'd1);
`else
        chkn("t3_rd_count",  64'(r_cnt), 64'd64);
        chkn("t3_words",     64'(words_out), 64'd64);
        chkn("t3_ufl_cnt",   64'(ufl_cnt), 64'd3);
`endif
        chk1("t3_underflow", underflow, 1'b1);
        chk1("t3_done_seen", r_done_at >= 0, 1'b1);

        // Abort at issued == 10 of a 50-word run.
        run_case(50, -1, 0, 0, 10, 0, 0, 0, 200);
        chk1("t5_abort_rd",   r_abort_rd, 1'b0);
        chk1("t5_busy_after", r_busy_after, 1'b0);
        chk1("t5_no_done",    r_done_at < 0, 1'b1);
        chkn("t5_rd_count",   64'(r_cnt), 64'd10);

        // Asynchronous reset in the middle of STREAM.
        cyc(1'b1, 1'b0, CNT_W'(50), 1'b0);
        for (int i = 0; i < 60 && !(m_phase == MP_STREAM && m_issued >= 5); i++)
            cyc(1'b0, 1'b0, CNT_W'(0), 1'b0);
        start      = 1'b0;
        abort      = 1'b0;
        fifo_empty = 1'b0;
        fifo_valid = valid_pipe;
        #1;
        chk1("t5_rd_before_rst", fifo_rd_en, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("t5_rd_in_rst",   fifo_rd_en, 1'b0);
        chk1("t5_busy_in_rst", busy, 1'b0);
        chkn("t5_words_rst",   64'(words_out), 64'd0);
        model_reset();
        valid_pipe = 1'b0;
        fifo_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Prefill restart at prefill cycle 8, then a start while busy.
        run_case(40, -1, 0, 9, -1, 40, 5, 0, 300);
        chkn("t6_first_rd", 64'(r_first), 64'd26);
        chkn("t6_rd_count", 64'(r_cnt), 64'd40);
        chkn("t6_words",    64'(words_out), 64'd40);
        chkn("t6_done_at",  64'(r_done_at), 64'(r_last + 2));

        // Randomized runs against the model.
        for (int k = 0; k < 20; k++) begin
            rnw = int'($urandom_range(60, 0));
            rab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(60, 0)) : -1;
            rbs = int'($urandom_range(80, 1));
            run_case(rnw, -1, 0, int'($urandom_range(30, 0)), rab, rbs,
                     int'($urandom_range(100, 1)), 20, 800);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_stream_sequencer.md
Name: pattern_stream_sequencer

Overview:
- Read-side controller for the 256-in/64-out pattern FIFO, in the stream clock domain.
- Drives the FIFO read enable, which is also the sensor stream-enable, for exactly num_words 64-bit words per run after a prefill wait.
- Counts issued and returned words, flags underflow gaps, and reports done.
- Sits directly downstream of the pattern FIFO and feeds the ODDR stage and the stream-enable delay register.

Parameters:
- CNT_W, 32, width of the word counters and num_words.
- PREFILL_CYC, 16, consecutive cycles of FIFO non-empty required before streaming starts.
- UFL_W, 16, width of the saturating underflow counter.

Ports:
- clk  input  1  stream clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a run; honoured only in IDLE or DONE.
- abort  input  1  single-cycle pulse; returns to IDLE from any state.
- num_words  input  CNT_W  64-bit words to stream; sampled on an accepted start.
- fifo_empty  input  1  pattern FIFO empty flag.
- fifo_valid  input  1  pattern FIFO dout valid; arrives 1 cycle after an accepted read.
- fifo_rd_en  output  1  FIFO read enable / stream enable; combinational.
- busy  output  1  high in PREFILL, STREAM, DRAIN.
- done  output  1  1-cycle pulse on entry to DONE.
- underflow  output  1  sticky; set on any underflow gap; cleared by start.
- ufl_cnt  output  UFL_W  saturating underflow-gap count; cleared by start.
- words_out  output  CNT_W  count of fifo_valid beats in the current run.

Behaviour:
- Reset values: state IDLE; all counters 0; busy=0, done=0, underflow=0, ufl_cnt=0, words_out=0. fifo_rd_en=0 because state is IDLE.
- States: IDLE, PREFILL, STREAM, DRAIN, DONE.
- IDLE/DONE --start--> PREFILL.
  - On entry: latch num_words to tgt; clear issued, words_out, ufl_cnt, underflow, prefill counter.
  - If num_words==0: go straight to DONE next cycle instead; done pulses; no reads issued.
- PREFILL:
  - pf_cnt increments while !fifo_empty; resets to 0 on any empty cycle.
  - pf_cnt==PREFILL_CYC-1 with !fifo_empty -> STREAM.
  - PREFILL_CYC=0 or 1 means enter STREAM on the first non-empty cycle.
- STREAM:
  - fifo_rd_en = !fifo_empty && (issued != tgt) && !abort.
  - issued increments on each fifo_rd_en.
  - The cycle with issued==tgt-1 and fifo_rd_en -> DRAIN.
  - Underflow gap: a STREAM cycle with fifo_empty and issued != tgt. Sets underflow; ufl_cnt += 1, saturating at all-ones.
- DRAIN: fifo_rd_en=0; wait until words_out==tgt -> DONE.
- DONE: done=1 for the entry cycle only; the block stays in DONE until start or abort.
- words_out increments on every fifo_valid while busy; fifo_valid outside busy is ignored.
- abort has priority over every transition and over start in the same cycle.
  - fifo_rd_en is forced low in the abort cycle.
  - State goes to IDLE next edge; counters hold until the next start.
- start while busy is ignored.
- reset_n asserted mid-run: immediate return to reset values; fifo_rd_en drops asynchronously with the state.
- Counter wrap: issued and words_out never exceed tgt; no wrap within a run.

Optional Feature:
- Macro: PATTERN_STREAM_UFL_STOP_EN.
- Defined: the first underflow gap in STREAM aborts the run.
  - Go to DRAIN, with tgt reloaded to the current issued count so DRAIN waits only for reads already in flight.
  - Then DONE with underflow=1 and ufl_cnt=1.
- Undefined: streaming stalls during gaps and resumes when the FIFO refills; all gaps are counted.

Decomposition:
- Shared package pattern_stream_pkg holds:
  - the state enum (IDLE=0, PREFILL=1, STREAM=2, DRAIN=3, DONE=4, 3 bits);
  - the default CNT_W/UFL_W constants.
- One sub-module, sat_counter (width parameter, clear, increment, saturate), used for ufl_cnt and pf_cnt.
- The FSM and the issued/words_out counters stay in the top module.

Test Plan:
1. Basic run:
   - Stimulus: FIFO holds 100 words; PREFILL_CYC=16; start with num_words=40.
   - Required: fifo_rd_en high exactly 40 cycles, contiguous, starting 17 cycles after start; done pulses 1 cycle after the 40th fifo_valid; underflow=0.
2. Zero-length run:
   - Stimulus: num_words=0, start.
   - Required: DONE the next cycle; done pulses once; fifo_rd_en never asserts; busy=0 throughout.
3. Underflow stall (macro undefined):
   - Stimulus: num_words=64; FIFO goes empty for 3 cycles after word 20.
   - Required: rd_en low for those 3 cycles; ufl_cnt=3; underflow=1; all 64 words still delivered; done asserts.
4. Underflow stop (macro defined, same stimulus as scenario 3):
   - Required: no reads after word 20; DONE with words_out=20, ufl_cnt=1.
5. Abort and reset:
   - Stimulus: abort at issued=10 during a num_words=50 run.
   - Required: rd_en low that cycle; IDLE next edge; no done pulse.
   - Then: reset_n low mid-STREAM drops rd_en and busy immediately.
6. Prefill restart and start-while-busy:
   - Stimulus: FIFO toggles empty at prefill cycle 8.
   - Required: pf_cnt restarts and STREAM entry is delayed by the full 16 non-empty cycles.
   - Then: a start while busy is ignored and num_words is not re-sampled.
